// File: rtl/ctrl_dac_spi.sv
// Serial writer for the QLA four-channel current DAC: one 24-bit frame per axis per sweep,
// with a single-entry pending buffer so the host never stalls on a busy bus.
module ctrl_dac_spi #(
  parameter int unsigned SCLK_HALF = 2,
  parameter logic [3:0]  DAC_CMD   = 4'b0011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dac1,
  input  logic [15:0] dac2,
  input  logic [15:0] dac3,
  input  logic [15:0] dac4,
  input  logic        dac_valid,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic        sclk,
  output logic        mosi,
  output logic        csel
);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  localparam logic [3:0] HalfLast = 4'(SCLK_HALF - 1);

  state_e           state_q, state_d;
  logic [3:0]       hcnt_q, hcnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [1:0]       k_q, k_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             csel_q, csel_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             pend_q, pend_d;
  logic [3:0][15:0] shadow_q, shadow_d;
  logic [3:0][15:0] pend_data_q, pend_data_d;
  logic [3:0][15:0] dac_in;
  logic [23:0]      frame;
  logic [4:0]       bit_nxt;
  logic             half_end;
  logic             start;

  assign dac_in   = {dac4, dac3, dac2, dac1};
  assign frame    = {DAC_CMD, 2'b00, k_q, shadow_q[k_q]};
  assign bit_nxt  = bit_q - 5'd1;
  assign half_end = (hcnt_q == HalfLast);
  assign start    = (state_q == StIdle) && (dac_valid || pend_q);

  // Request capture: IDLE consumes pending first; any request arriving outside that path is
  // parked in pending, and overwriting a parked request is flagged.
  always_comb begin
    shadow_d    = shadow_q;
    pend_data_d = pend_data_q;
    pend_d      = pend_q;
    ovr_d       = ovr_q;
    if (state_q == StIdle) begin
      if (pend_q) begin
        shadow_d = pend_data_q;
        pend_d   = dac_valid;
        if (dac_valid) pend_data_d = dac_in;
      end else if (dac_valid) begin
        shadow_d = dac_in;
      end
    end else if (dac_valid) begin
      pend_data_d = dac_in;
      pend_d      = 1'b1;
      if (pend_q) ovr_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    k_d     = k_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csel_d  = csel_q;
    done_d  = 1'b0;
    if (state_q != StIdle) hcnt_d = half_end ? 4'd0 : hcnt_q + 4'd1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSetup;
          hcnt_d  = 4'd0;
          bit_d   = 5'd23;
          k_d     = 2'd0;
          csel_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = DAC_CMD[3];
        end
      end
      StSetup: begin
        if (half_end) state_d = StShift;
      end
      StShift: begin
        // Data only moves on the falling sclk edge so it is stable across the rising edge.
        if (half_end) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 5'd0) begin
              state_d = StHold;
            end else begin
              bit_d  = bit_nxt;
              mosi_d = frame[bit_nxt];
            end
          end
        end
      end
      StHold: begin
        if (half_end) begin
          state_d = StGap;
          csel_d  = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      StGap: begin
        if (half_end) begin
          if (k_q == 2'd3) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StSetup;
            k_d     = k_q + 2'd1;
            bit_d   = 5'd23;
            csel_d  = 1'b0;
            mosi_d  = DAC_CMD[3];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      hcnt_q      <= 4'd0;
      bit_q       <= 5'd0;
      k_q         <= 2'd0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      csel_q      <= 1'b1;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      pend_q      <= 1'b0;
      shadow_q    <= '0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      bit_q       <= bit_d;
      k_q         <= k_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      csel_q      <= csel_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      pend_q      <= pend_d;
      shadow_q    <= shadow_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign overrun = ovr_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign csel    = csel_q;

endmodule

// File: tb/tb_ctrl_dac_spi.sv
// Directed bench for ctrl_dac_spi: default-timing instance plus a SCLK_HALF=1 instance.
module tb_ctrl_dac_spi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dac1, dac2, dac3, dac4;
  logic        dac_valid, dac_valid1;
  logic        busy, done, overrun, sclk, mosi, csel;
  logic        busy1, done1, overrun1, sclk1, mosi1, csel1;
  int          cyc;
  int          n_checks;
  int          n_pass;
  int          vt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ctrl_dac_spi #(.SCLK_HALF(2), .DAC_CMD(4'b0011)) dut (
    .clk(clk), .reset(rst_n), .dac1(dac1), .dac2(dac2), .dac3(dac3), .dac4(dac4),
    .dac_valid(dac_valid), .busy(busy), .done(done), .overrun(overrun),
    .sclk(sclk), .mosi(mosi), .csel(csel)
  );

  ctrl_dac_spi #(.SCLK_HALF(1), .DAC_CMD(4'b0011)) dut1 (
    .clk(clk), .reset(rst_n), .dac1(dac1), .dac2(dac2), .dac3(dac3), .dac4(dac4),
    .dac_valid(dac_valid1), .busy(busy1), .done(done1), .overrun(overrun1),
    .sclk(sclk1), .mosi(mosi1), .csel(csel1)
  );

  // Bus monitor for the default instance; samples 1 time unit after each rising clk.
  logic [23:0] sh;
  int          low_len, edges, glitch;
  logic        sclk_p = 1'b0, mosi_p = 1'b0, csel_p = 1'b1;
  logic [23:0] frames[$];
  int          lens[$], edge_q[$], fall_t[$], done_t[$];

  always begin
    @(posedge clk);
    #1;
    if (csel_p && !csel) begin
      fall_t.push_back(cyc);
      low_len = 0;
      edges   = 0;
    end
    if (!csel) begin
      low_len++;
      if (sclk && !sclk_p) begin
        sh = {sh[22:0], mosi};
        edges++;
      end
    end
    if (!csel_p && csel) begin
      frames.push_back(sh);
      lens.push_back(low_len);
      edge_q.push_back(edges);
    end
    if (mosi != mosi_p && sclk) glitch++;
    if (done) done_t.push_back(cyc);
    sclk_p = sclk;
    mosi_p = mosi;
    csel_p = csel;
  end

  int   edges1, glitch1;
  logic sclk1_p = 1'b0, mosi1_p = 1'b0, csel1_p = 1'b1;
  int   edge1_q[$], done1_t[$];

  always begin
    @(posedge clk);
    #1;
    if (csel1_p && !csel1) edges1 = 0;
    if (!csel1 && sclk1 && !sclk1_p) edges1++;
    if (!csel1_p && csel1) edge1_q.push_back(edges1);
    if (mosi1 != mosi1_p && sclk1) glitch1++;
    if (done1) done1_t.push_back(cyc);
    sclk1_p = sclk1;
    mosi1_p = mosi1;
    csel1_p = csel1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic pulse(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] d);
    dac1      = a;
    dac2      = b;
    dac3      = c;
    dac4      = d;
    dac_valid = 1'b1;
    vt        = cyc;
    @(negedge clk);
    dac_valid = 1'b0;
  endtask

  task automatic clear_mon();
    frames.delete();
    lens.delete();
    edge_q.delete();
    fall_t.delete();
    done_t.delete();
    glitch = 0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (done_t.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("done_wait", done_t.size(), n);
  endtask

  // Expected frame k is {cmd 4'h3, addr k, data}.
  task automatic check_frames(input int base, input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3);
    logic [15:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int k = 0; k < 4; k++)
      check($sformatf("frame%0d_k%0d", base, k),
            (frames.size() > base + k) ? 32'(frames[base + k]) : 32'hFFFF_FFFF,
            {8'h00, 4'h3, 4'(k), d[k]});
  endtask

  initial begin
    int v0;
    int idle_bad;
    int t;
    idle_bad   = 0;
    rst_n      = 1'b0;
    dac_valid  = 1'b0;
    dac_valid1 = 1'b0;
    dac1 = '0; dac2 = '0; dac3 = '0; dac4 = '0;
    repeat (3) @(negedge clk);
    check("rst_csel", 32'(csel), 1);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovr", 32'(overrun), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!csel || sclk || mosi || busy) idle_bad++;
    end
    check("idle_quiet", idle_bad, 0);
    check("idle_frames", frames.size(), 0);

    // Basic sweep; inputs scrambled right after capture.
    clear_mon();
    pulse(16'hA5C3, 16'h0001, 16'hFFFF, 16'h8000);
    v0 = vt;
    dac1 = 16'hDEAD; dac2 = 16'hBEEF; dac3 = 16'h5555; dac4 = 16'h0F0F;
    wait_done(1, 1000);
    repeat (3) @(negedge clk);
    check("frames_n", frames.size(), 4);
    check_frames(0, 16'hA5C3, 16'h0001, 16'hFFFF, 16'h8000);
    check("latency", (done_t.size() > 0) ? done_t[0] - v0 : -1, 409);
    check("done_once", done_t.size(), 1);
    check("csel_next", (fall_t.size() > 0) ? fall_t[0] - v0 : -1, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("csel_len_k%0d", k), (lens.size() > k) ? lens[k] : -1, 100);
      check($sformatf("edges_k%0d", k), (edge_q.size() > k) ? edge_q[k] : -1, 24);
    end
    check("frame_period", (fall_t.size() > 1) ? fall_t[1] - fall_t[0] : -1, 102);
    check("mosi_stable", glitch, 0);
    check("busy_after", 32'(busy), 0);

    // SCLK_HALF=1 instance.
    dac1 = 16'h1357; dac2 = 16'h2468; dac3 = 16'h0000; dac4 = 16'h7FFF;
    dac_valid1 = 1'b1;
    v0 = cyc;
    @(negedge clk);
    dac_valid1 = 1'b0;
    t = 0;
    while (done1_t.size() < 1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("h1_done_wait", done1_t.size(), 1);
    check("h1_latency", (done1_t.size() > 0) ? done1_t[0] - v0 : -1, 205);
    for (int k = 0; k < 4; k++)
      check($sformatf("h1_edges_k%0d", k), (edge1_q.size() > k) ? edge1_q[k] : -1, 24);
    check("h1_mosi_stable", glitch1, 0);
    check("h1_ovr", 32'(overrun1), 0);
    check("h1_busy_after", 32'(busy1), 0);

    // Pending request mid-sweep.
    clear_mon();
    pulse(16'hA5C3, 16'h0001, 16'hFFFF, 16'h8000);
    v0 = vt;
    repeat (98) @(negedge clk);
    pulse(16'h1234, 16'h1111, 16'h2222, 16'h3333);
    check("pend_no_ovr", 32'(overrun), 0);
    wait_done(2, 1500);
    repeat (3) @(negedge clk);
    check("pend_frames_n", frames.size(), 8);
    check_frames(4, 16'h1234, 16'h1111, 16'h2222, 16'h3333);
    check("pend_gap", (fall_t.size() > 4 && done_t.size() > 0) ? fall_t[4] - done_t[0] : -1, 1);
    check("pend_sweep", (done_t.size() > 1) ? done_t[1] - done_t[0] : -1, 409);
    check("pend_no_ovr_end", 32'(overrun), 0);

    // Request in the done cycle starts the next sweep after a single idle cycle.
    clear_mon();
    pulse(16'hA5C3, 16'h0001, 16'hFFFF, 16'h8000);
    v0 = vt;
    while (cyc < v0 + 409) @(negedge clk);
    check("sim_done_hi", 32'(done), 1);
    check("sim_busy_lo", 32'(busy), 0);
    pulse(16'h0F0F, 16'h1E1E, 16'h2D2D, 16'h3C3C);
    check("sim_busy_hi", 32'(busy), 1);
    wait_done(2, 1500);
    repeat (3) @(negedge clk);
    check_frames(4, 16'h0F0F, 16'h1E1E, 16'h2D2D, 16'h3C3C);
    check("sim_gap", (fall_t.size() > 4 && done_t.size() > 0) ? fall_t[4] - done_t[0] : -1, 1);
    check("sim_no_ovr", 32'(overrun), 0);

    // Two requests during one sweep: last one wins, overrun flagged.
    clear_mon();
    pulse(16'hA5C3, 16'h0001, 16'hFFFF, 16'h8000);
    v0 = vt;
    repeat (98) @(negedge clk);
    pulse(16'h1234, 16'h1111, 16'h2222, 16'h3333);
    repeat (49) @(negedge clk);
    pulse(16'hBEEF, 16'h0102, 16'h0304, 16'h0506);
    check("ovr_set", 32'(overrun), 1);
    wait_done(2, 1500);
    repeat (3) @(negedge clk);
    check_frames(4, 16'hBEEF, 16'h0102, 16'h0304, 16'h0506);
    check("ovr_sticky", 32'(overrun), 1);

    // Reset during bit 10 of channel 2.
    clear_mon();
    pulse(16'hA5C3, 16'h0001, 16'hFFFF, 16'h8000);
    v0 = vt;
    while (cyc < v0 + 260) @(negedge clk);
    check("mid_csel_lo", 32'(csel), 0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_csel", 32'(csel), 1);
    check("arst_sclk", 32'(sclk), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_ovr", 32'(overrun), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (1000) @(negedge clk);
    check("post_rst_frames", frames.size(), 0);
    check("post_rst_fall", fall_t.size(), 0);
    check("post_rst_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
